fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_skid.sv | 41 ++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StReq,
    StDrop,
    StFull
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC_DEFAULT   = 1;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/acknowledge bus seen from the fetch stage.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer parking a fetched word and its PC while decode is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic [31:0] data_o,
  output logic [31:0] pc_o
);

  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    if (load_i) begin
      data_d = data_i;
      pc_d   = pc_i;
    end else if (unload_i) begin
      data_d = '0;
      pc_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request FSM, redirect handling and IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  ifid_inst_q, ifid_inst_d;
  logic [31:0]  ifid_pc_q, ifid_pc_d;

  logic        skid_load, skid_unload;
  logic [31:0] skid_data, skid_pc;
  logic        slot_free;
  logic [31:0] pc_seq;

  assign slot_free = !ifid_valid_q || !stall_i;
  assign pc_seq    = pc_q + PC_INC;

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (imem.imem_rdata),
    .pc_i     (pc_q),
    .data_o   (skid_data),
    .pc_o     (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;

    unique case (state_q)
      StReq, StDrop: begin
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          // A coincident ack completes the in-flight request, so the target can be used now.
          if (imem.imem_ack) begin
            pc_d    = redirect_pc_i;
            state_d = StReq;
          end else begin
            pend_d  = redirect_pc_i;
            state_d = StDrop;
          end
        end else if (imem.imem_ack && state_q == StDrop) begin
          pc_d    = pend_q;
          state_d = StReq;
          if (slot_free) ifid_valid_d = 1'b0;
        end else if (imem.imem_ack) begin
          pc_d = pc_seq;
          if (slot_free) begin
            ifid_inst_d  = imem.imem_rdata;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = StFull;
          end
        end else if (slot_free) begin
          ifid_valid_d = 1'b0;
        end
      end
      StFull: begin
        // No request is outstanding here, so any ack is a protocol error and ignored.
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          pc_d         = redirect_pc_i;
          skid_unload  = 1'b1;
          state_d      = StReq;
        end else if (!stall_i) begin
          ifid_inst_d  = skid_data;
          ifid_pc_d    = skid_pc;
          ifid_valid_d = 1'b1;
          skid_unload  = 1'b1;
          state_d      = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
      ifid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  // Request drops straight from reset so the memory abandons any in-flight access.
  assign imem.imem_req  = !rst && (state_q != StFull);
  assign imem.imem_addr = pc_q;
  assign ifid_valid_o   = ifid_valid_q;
  assign ifid_inst_o    = ifid_inst_q;
  assign ifid_pc_o      = ifid_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, wrap/reset sequences, random vs model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, redir;
  logic [31:0] rpc;
  logic        v, w_v;
  logic [31:0] inst, ifpc, w_inst, w_ifpc;

  fetch_if bus ();
  fetch_if bus_w ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0000;
  endfunction

  assign bus.imem_rdata   = mem_word(bus.imem_addr);
  assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus.master),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .ifid_valid_o  (v),
    .ifid_inst_o   (inst),
    .ifid_pc_o     (ifpc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .PC_INC(1)) dut_w (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus_w.master),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .ifid_valid_o  (w_v),
    .ifid_inst_o   (w_inst),
    .ifid_pc_o     (w_ifpc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t, input logic a,
                              input logic ev, input logic [31:0] ep, input logic eq,
                              input logic [31:0] ea);
    vec_t x;
    x.stall = s; x.redir = r; x.rpc = t; x.ack = a;
    x.exp_v = ev; x.exp_pc = ep; x.exp_req = eq; x.exp_addr = ea;
    return x;
  endfunction

  // Behavioural model: PC, IF/ID contents, a discard flag for the in-flight request and a
  // queue holding at most one parked word {pc, inst}.
  logic        m_v, m_drop;
  logic [31:0] m_inst, m_ifpc, m_pc, m_tgt;
  logic [63:0] m_skq[$];

  task automatic model_reset();
    m_v = 0; m_drop = 0; m_inst = 0; m_ifpc = 0; m_pc = 0; m_tgt = 0;
    m_skq.delete();
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] t, input logic a);
    logic [31:0] rd;
    logic        free;
    rd   = mem_word(m_pc);
    free = !m_v || !s;
    if (m_skq.size() != 0) begin
      if (r) begin
        m_skq.delete(); m_v = 0; m_pc = t;
      end else if (!s) begin
        {m_ifpc, m_inst} = m_skq.pop_front(); m_v = 1;
      end
    end else if (r) begin
      m_v = 0;
      if (a) begin m_pc = t; m_drop = 0; end
      else begin m_drop = 1; m_tgt = t; end
    end else if (a && m_drop) begin
      m_pc = m_tgt; m_drop = 0;
      if (free) m_v = 0;
    end else if (a && free) begin
      m_inst = rd; m_ifpc = m_pc; m_v = 1; m_pc = m_pc + 32'd1;
    end else if (a) begin
      m_skq.push_back({m_pc, rd}); m_pc = m_pc + 32'd1;
    end else if (free) begin
      m_v = 0;
    end
  endtask

  initial begin
    stall = 0; redir = 0; rpc = 0;
    bus.imem_ack = 0; bus_w.imem_ack = 0;

    vecs[0]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   1, 32'h1);
    vecs[1]  = mk(0, 0, 32'h0,   1, 1, 32'h1,   1, 32'h2);
    vecs[2]  = mk(0, 0, 32'h0,   1, 1, 32'h2,   1, 32'h3);
    vecs[3]  = mk(0, 0, 32'h0,   1, 1, 32'h3,   1, 32'h4);
    vecs[4]  = mk(1, 0, 32'h0,   1, 1, 32'h3,   0, 32'h5);
    vecs[5]  = mk(1, 0, 32'h0,   0, 1, 32'h3,   0, 32'h5);
    vecs[6]  = mk(1, 0, 32'h0,   0, 1, 32'h3,   0, 32'h5);
    vecs[7]  = mk(0, 0, 32'h0,   0, 1, 32'h4,   1, 32'h5);
    vecs[8]  = mk(0, 0, 32'h0,   1, 1, 32'h5,   1, 32'h6);
    vecs[9]  = mk(0, 0, 32'h0,   0, 0, 32'h5,   1, 32'h6);
    vecs[10] = mk(0, 1, 32'h40,  0, 0, 32'h5,   1, 32'h6);
    vecs[11] = mk(0, 0, 32'h0,   0, 0, 32'h5,   1, 32'h6);
    vecs[12] = mk(0, 0, 32'h0,   0, 0, 32'h5,   1, 32'h6);
    vecs[13] = mk(0, 0, 32'h0,   1, 0, 32'h5,   1, 32'h40);
    vecs[14] = mk(0, 0, 32'h0,   1, 1, 32'h40,  1, 32'h41);
    vecs[15] = mk(1, 1, 32'h80,  1, 0, 32'h40,  1, 32'h80);
    vecs[16] = mk(0, 0, 32'h0,   1, 1, 32'h80,  1, 32'h81);
    vecs[17] = mk(0, 1, 32'h100, 0, 0, 32'h80,  1, 32'h81);
    vecs[18] = mk(0, 1, 32'h200, 0, 0, 32'h80,  1, 32'h81);
    vecs[19] = mk(0, 0, 32'h0,   1, 0, 32'h80,  1, 32'h200);
    vecs[20] = mk(0, 1, 32'h300, 0, 0, 32'h80,  1, 32'h200);
    vecs[21] = mk(0, 1, 32'h400, 1, 0, 32'h80,  1, 32'h400);
    vecs[22] = mk(0, 0, 32'h0,   1, 1, 32'h400, 1, 32'h401);
    vecs[23] = mk(1, 0, 32'h0,   1, 1, 32'h400, 0, 32'h402);
    vecs[24] = mk(1, 0, 32'h0,   1, 1, 32'h400, 0, 32'h402);
    vecs[25] = mk(1, 1, 32'h10,  0, 0, 32'h400, 1, 32'h10);
    vecs[26] = mk(0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h11);

    repeat (2) @(negedge clk);
    chk("req_in_reset", 32'(bus.imem_req), 32'h0);
    rst = 0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(v), 32'h0);
    chk("rst_w_addr", bus_w.imem_addr, 32'hFFFF_FFFF);

    for (int i = 0; i < 27; i++) begin
      stall = vecs[i].stall; redir = vecs[i].redir; rpc = vecs[i].rpc;
      bus.imem_ack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d_pc", i), ifpc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_inst", i), inst, mem_word(vecs[i].exp_pc));
      end
    end
    stall = 0; redir = 0; bus.imem_ack = 0;

    // PC wrap on the instance reset to the top of the address space.
    bus_w.imem_ack = 1;
    @(negedge clk);
    bus_w.imem_ack = 0;
    chk("wrap_valid", 32'(w_v), 32'h1);
    chk("wrap_ifpc", w_ifpc, 32'hFFFF_FFFF);
    chk("wrap_inst", w_inst, mem_word(32'hFFFF_FFFF));
    chk("wrap_addr", bus_w.imem_addr, 32'h0);

    // Reset asserted mid-request, between clock edges.
    @(negedge clk);
    chk("pre_rst_req", 32'(bus.imem_req), 32'h1);
    #2 rst = 1;
    #1;
    chk("async_req_drop", 32'(bus.imem_req), 32'h0);
    chk("async_addr", bus.imem_addr, 32'h0);
    chk("async_valid", 32'(v), 32'h0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("restart_req", 32'(bus.imem_req), 32'h1);
    chk("restart_addr", bus.imem_addr, 32'h0);
    chk("restart_w_addr", bus_w.imem_addr, 32'hFFFF_FFFF);
    model_reset();

    for (int c = 0; c < 600; c++) begin
      logic exp_req;
      logic s, r, a;
      logic [31:0] t;
      exp_req = (m_skq.size() == 0);
      s = ($urandom_range(99) < 30);
      r = ($urandom_range(99) < 10);
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1))) : $urandom;
      a = exp_req ? ($urandom_range(99) < 60) : ($urandom_range(99) < 10);
      stall = s; redir = r; rpc = t; bus.imem_ack = a;
      model_step(s, r, t, a);
      @(negedge clk);
      chk("rnd_valid", 32'(v), 32'(m_v));
      chk("rnd_req", 32'(bus.imem_req), 32'(m_skq.size() == 0));
      chk("rnd_addr", bus.imem_addr, m_pc);
      if (m_v) begin
        chk("rnd_ifpc", ifpc, m_ifpc);
        chk("rnd_inst", inst, m_inst);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
